// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU sequencer: op codes, branch
// condition codes, FSM state encodings and the flag-writing op classifier.
package alu_pkg;

  localparam int ALU_W   = 16;
  localparam int ALU_OPW = 4;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_NAND  = 4'h2;
  localparam logic [3:0] OP_XOR   = 4'h3;
  localparam logic [3:0] OP_INC   = 4'h4;
  localparam logic [3:0] OP_SRA   = 4'h5;
  localparam logic [3:0] OP_SRL   = 4'h6;
  localparam logic [3:0] OP_SLL   = 4'h7;
  localparam logic [3:0] OP_LW    = 4'h8;
  localparam logic [3:0] OP_SW    = 4'h9;
  localparam logic [3:0] OP_LHB   = 4'hA;
  localparam logic [3:0] OP_LLB   = 4'hB;
  localparam logic [3:0] OP_B     = 4'hC;
  localparam logic [3:0] OP_CALL  = 4'hD;
  localparam logic [3:0] OP_RET   = 4'hE;
  localparam logic [3:0] OP_NO_OP = 4'hF;

  typedef enum logic [2:0] {
    COND_NE = 3'b000,
    COND_EQ = 3'b001,
    COND_GT = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_LE = 3'b101,
    COND_OV = 3'b110,
    COND_UN = 3'b111
  } cond_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_EXEC  = 2'd1;
  localparam state_t ST_CALL2 = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic logic is_flag_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) ||
           (op == OP_XOR) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation against the N/Z/V flags.
module branch_cond_eval
  import alu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NE: taken = ~z;
      COND_EQ: taken = z;
      COND_GT: taken = ~z & ~n;
      COND_LT: taken = n;
      COND_GE: taken = ~n;
      COND_LE: taken = n | z;
      COND_OV: taken = v;
      COND_UN: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// EX-stage sequencer for the shared ALU: accepts decoded ops, drives the ALU
// from latched operands, registers results, owns the N/Z/V flags.
//
// state | meaning
// IDLE  | waiting for an op, in_ready=1
// EXEC  | first ALU pass from latched operands
// CALL2 | second CALL pass, target passthrough ADD(in_b,0)
// DONE  | result valid, held while stall; may accept next op
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int W   = 16,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [2:0]     in_cond,
  input  logic           stall,
  input  logic           flush,
  output logic [OPW-1:0] alu_op,
  output logic [W-1:0]   alu_in1,
  output logic [W-1:0]   alu_in2,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_n,
  input  logic           alu_z,
  input  logic           alu_v,
  output logic           out_valid,
  output logic [W-1:0]   out_result,
  output logic [W-1:0]   out_target,
  output logic           br_taken,
  output logic           flag_n,
  output logic           flag_z,
  output logic           flag_v
);

  state_t         state;
  logic [OPW-1:0] op_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [2:0]     cond_r;
  logic           accept;
  logic           cond_true;

  branch_cond_eval u_cond (
    .cond  (cond_r),
    .n     (flag_n),
    .z     (flag_z),
    .v     (flag_v),
    .taken (cond_true)
  );

  // flush and reset both block a same-cycle accept
  always_comb begin
    in_ready = 1'b0;
    if (!rst && !flush) begin
      case (state)
        ST_IDLE: in_ready = 1'b1;
        ST_DONE: in_ready = ~stall;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    alu_op  = OP_NO_OP;
    alu_in1 = '0;
    alu_in2 = '0;
    case (state)
      ST_EXEC: begin
        case (op_r)
          OP_CALL: begin
            alu_op  = OP_SUB;
            alu_in1 = a_r;
            alu_in2 = W'(1);
          end
          OP_RET: begin
            alu_op  = OP_ADD;
            alu_in1 = a_r;
            alu_in2 = W'(1);
          end
          OP_B: begin
            alu_op = OP_NO_OP;
          end
          default: begin
            alu_op  = op_r;
            alu_in1 = a_r;
            alu_in2 = b_r;
          end
        endcase
      end
      ST_CALL2: begin
        alu_op  = OP_ADD;
        alu_in1 = b_r;
        alu_in2 = '0;
      end
      default: begin
        alu_op = OP_NO_OP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_r       <= OP_NO_OP;
      a_r        <= '0;
      b_r        <= '0;
      cond_r     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_target <= '0;
      br_taken   <= 1'b0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b0;
      flag_v     <= 1'b0;
    end else if (flush && (state != ST_IDLE)) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      br_taken  <= 1'b0;
    end else begin
      if (accept) begin
        op_r   <= in_op;
        a_r    <= in_a;
        b_r    <= in_b;
        cond_r <= in_cond;
      end
      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_EXEC;
        end
        ST_EXEC: begin
          out_result <= (op_r == OP_B) ? '0 : alu_out;
          if (op_r == OP_CALL) begin
            state <= ST_CALL2;
          end else begin
            state      <= ST_DONE;
            out_valid  <= 1'b1;
            out_target <= '0;
            br_taken   <= (op_r == OP_B) & cond_true;
            if (is_flag_op(op_r)) begin
              flag_n <= alu_n;
              flag_z <= alu_z;
              flag_v <= alu_v;
            end
          end
        end
        ST_CALL2: begin
          state      <= ST_DONE;
          out_valid  <= 1'b1;
          out_target <= alu_out;
          br_taken   <= 1'b0;
        end
        ST_DONE: begin
          if (!stall) begin
            out_valid <= 1'b0;
            br_taken  <= 1'b0;
            state     <= accept ? ST_EXEC : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU alongside.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_cond;
  logic        stall;
  logic        flush;
  logic [3:0]  alu_op;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [15:0] alu_out;
  logic        alu_n;
  logic        alu_z;
  logic        alu_v;
  logic        out_valid;
  logic [15:0] out_result;
  logic [15:0] out_target;
  logic        br_taken;
  logic        flag_n;
  logic        flag_z;
  logic        flag_v;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_cond    (in_cond),
    .stall      (stall),
    .flush      (flush),
    .alu_op     (alu_op),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_out    (alu_out),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_v      (alu_v),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_target (out_target),
    .br_taken   (br_taken),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .flag_v     (flag_v)
  );

  // external ALU stand-in
  always_comb begin
    alu_out = 16'h0000;
    alu_v   = 1'b0;
    case (alu_op)
      4'h0: begin
        alu_out = alu_in1 + alu_in2;
        alu_v   = (alu_in1[15] == alu_in2[15]) && (alu_out[15] != alu_in1[15]);
      end
      4'h1: begin
        alu_out = alu_in1 - alu_in2;
        alu_v   = (alu_in1[15] != alu_in2[15]) && (alu_out[15] != alu_in1[15]);
      end
      4'h2: alu_out = ~(alu_in1 & alu_in2);
      4'h3: alu_out = alu_in1 ^ alu_in2;
      4'h4: alu_out = alu_in1 + 16'h0001;
      4'h5: alu_out = $signed(alu_in1) >>> alu_in2[3:0];
      4'h6: alu_out = alu_in1 >> alu_in2[3:0];
      4'h7: alu_out = alu_in1 << alu_in2[3:0];
      default: alu_out = 16'h0000;
    endcase
    alu_n = alu_out[15];
    alu_z = (alu_out == 16'h0000);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] cond);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_cond  = cond;
  endtask

  // accept then one EXEC cycle; leaves the bench at DONE entry for non-CALL ops
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] cond);
    drive(op, a, b, cond);
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  logic [7:0] cond_exp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 4'hF; in_a = '0; in_b = '0;
    in_cond = '0; stall = 1'b0; flush = 1'b0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_alu_op", alu_op, 4'hF);
    check("rst_result", out_result, 0);
    check("rst_flags", {flag_n, flag_z, flag_v}, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);

    // ADD overflow into sign bit
    drive(4'h0, 16'h7FFF, 16'h0001, 3'b000);
    tick();
    in_valid = 1'b0;
    check("add_exec_valid", out_valid, 0);
    check("add_exec_in_ready", in_ready, 0);
    check("add_exec_alu", {alu_op, alu_in1, alu_in2}, {4'h0, 16'h7FFF, 16'h0001});
    tick();
    check("add_valid", out_valid, 1);
    check("add_result", out_result, 16'h8000);
    check("add_flags", {flag_n, flag_z, flag_v}, 3'b101);
    check("add_br", br_taken, 0);

    // all branch conditions against N=1 Z=0 V=1 (bit i = cond i)
    cond_exp = 8'b1110_1001;
    for (int i = 0; i < 8; i++) begin
      drive(4'hC, 16'h1111, 16'h2222, 3'(i));
      tick();
      in_valid = 1'b0;
      check("b_alu_op", alu_op, 4'hF);
      tick();
      check($sformatf("b_cond%0d_taken", i), br_taken, cond_exp[i]);
      check($sformatf("b_cond%0d_flags", i), {flag_n, flag_z, flag_v}, 3'b101);
    end

    // SUB to zero, B EQ back-to-back, then SLL keeps Z
    run_op(4'h1, 16'h0005, 16'h0005, 3'b000);
    check("sub_result", out_result, 16'h0000);
    check("sub_flags", {flag_n, flag_z, flag_v}, 3'b010);
    run_op(4'hC, 16'h0000, 16'h0000, 3'b001);
    check("beq_taken", br_taken, 1);
    check("beq_valid", out_valid, 1);
    run_op(4'h7, 16'h0001, 16'h0003, 3'b000);
    check("sll_result", out_result, 16'h0008);
    check("sll_br", br_taken, 0);
    check("sll_flags", {flag_n, flag_z, flag_v}, 3'b010);
    tick();
    check("idle_valid", out_valid, 0);

    // CALL two-pass sequence
    drive(4'hD, 16'h0100, 16'h0040, 3'b000);
    tick();
    in_valid = 1'b0;
    check("call_exec_alu", {alu_op, alu_in1, alu_in2}, {4'h1, 16'h0100, 16'h0001});
    check("call_exec_valid", out_valid, 0);
    tick();
    check("call2_valid", out_valid, 0);
    check("call2_alu", {alu_op, alu_in1, alu_in2}, {4'h0, 16'h0040, 16'h0000});
    check("call2_in_ready", in_ready, 0);
    tick();
    check("call_valid", out_valid, 1);
    check("call_result", out_result, 16'h00FF);
    check("call_target", out_target, 16'h0040);
    check("call_flags", {flag_n, flag_z, flag_v}, 3'b010);
    tick();

    // RET
    run_op(4'hE, 16'h00FF, 16'h0000, 3'b000);
    check("ret_result", out_result, 16'h0100);
    check("ret_flags", {flag_n, flag_z, flag_v}, 3'b010);
    tick();

    // XOR held under stall, next op waiting
    stall = 1'b1;
    drive(4'h3, 16'h00F0, 16'h00FF, 3'b000);
    tick();
    drive(4'h0, 16'h0002, 16'h0003, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_valid", i), out_valid, 1);
      check($sformatf("stall%0d_result", i), out_result, 16'h000F);
      check($sformatf("stall%0d_in_ready", i), in_ready, 0);
    end
    check("xor_flags", {flag_n, flag_z, flag_v}, 3'b000);
    stall = 1'b0;
    #1;
    check("unstall_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("next_exec_alu", {alu_op, alu_in1, alu_in2}, {4'h0, 16'h0002, 16'h0003});
    check("next_exec_valid", out_valid, 0);
    tick();
    check("next_result", out_result, 16'h0005);
    tick();

    // flush in CALL2 (SP=1 so the SUB pass yields zero)
    drive(4'hD, 16'h0001, 16'h1234, 3'b000);
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_valid", out_valid, 0);
    check("flush_in_ready_after", in_ready, 1);
    check("flush_flags", {flag_n, flag_z, flag_v}, 3'b000);
    check("flush_target", out_target, 16'h0000);
    check("flush_alu_op", alu_op, 4'hF);

    // reset during EXEC with N=1
    run_op(4'h0, 16'h7FFF, 16'h0001, 3'b000);
    check("pre_rst_flag_n", flag_n, 1);
    drive(4'h0, 16'h0001, 16'h0001, 3'b000);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_outs", {out_valid, br_taken, out_result, out_target}, 0);
    check("mid_rst_flags", {flag_n, flag_z, flag_v}, 0);
    check("mid_rst_alu", {alu_op, alu_in1, alu_in2}, {4'hF, 32'h0});
    check("mid_rst_in_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
